// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM sample sequencer: FSM states and the
// modulator configuration bundle that is shadowed between periods.
package pwm_seq_pkg;

    localparam int unsigned CFG_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        STOP
    } state_t;

    typedef struct packed {
        logic [CFG_BITS-1:0] compare_max;
        logic                dual_slope_en;
        logic                double_slope_en;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_sample_fifo.sv
// Synchronous sample FIFO with occupancy output and wrap-around pointers.
// Read data is the head entry; a same-cycle push never bypasses to it.
module pwm_sample_fifo
    import pwm_seq_pkg::*;
#(
    parameter int BITS       = 11,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [BITS-1:0]       push_data,
    input  logic                  pop,
    output logic [BITS-1:0]       pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [BITS-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pwm_sample_sequencer.sv
// Feeds the pulse-width modulator one clamped sample per period and shadows its config.
// Define PWM_SEQ_UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of 0.
module pwm_sample_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int BITS        = CFG_BITS,
    parameter int DEPTH_LOG2  = 2,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cfg_write,
    input  logic [BITS-1:0]     cfg_compare_max,
    input  logic                cfg_dual_slope_en,
    input  logic                cfg_double_slope_en,
    input  logic [BITS-1:0]     in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                pulse_done,
    output logic                pwm_reset,
    output logic [BITS-1:0]     pulse_width,
    output logic [BITS-1:0]     compare_max,
    output logic                dual_slope_en,
    output logic                double_slope_en,
    output logic                running,
    output logic                underrun,
    output logic [DEPTH_LOG2:0] fifo_level
);

    state_t          state;
    state_t          next_state;
    pwm_cfg_t        pending;
    pwm_cfg_t        active;
    pwm_cfg_t        next_cfg;
    logic            pending_valid;
    logic            apply_cfg;
    logic [BITS-1:0] next_cm;
    logic [BITS-1:0] head;
    logic [BITS-1:0] fill_value;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            primed;
    logic            zero_pw;
    logic            fill;
    logic            set_underrun;
    logic            clr_underrun;

    function automatic logic [BITS-1:0] clamp(
        input logic [BITS-1:0] s,
        input logic [BITS-1:0] m
    );
        return (s > m) ? m : s;
    endfunction

    pwm_sample_fifo #(
        .BITS       (BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign in_ready        = !full;
    assign push            = in_valid && in_ready;
    assign primed          = (fifo_level >= (DEPTH_LOG2+1)'(PRIME_LEVEL));
    assign running         = (state == RUN) || (state == STOP);
    assign compare_max     = BITS'(active.compare_max);
    assign dual_slope_en   = active.dual_slope_en;
    assign double_slope_en = active.double_slope_en;

    // Config only moves while the modulator is held, or exactly at a period boundary.
    assign apply_cfg = pending_valid &&
                       ((state == IDLE) || (state == PRIME) || pulse_done);
    assign next_cfg  = apply_cfg ? pending : active;
    assign next_cm   = BITS'(next_cfg.compare_max);

`ifdef PWM_SEQ_UNDERRUN_HOLD_EN
    logic [BITS-1:0] last_sample;

    always_ff @(posedge clk) begin
        if (reset)    last_sample <= '0;
        else if (pop) last_sample <= head;
    end

    assign fill_value = clamp(last_sample, next_cm);
`else
    assign fill_value = '0;
`endif

    always_comb begin
        next_state   = state;
        pop          = 1'b0;
        zero_pw      = 1'b0;
        fill         = 1'b0;
        set_underrun = 1'b0;
        clr_underrun = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    next_state   = PRIME;
                    clr_underrun = 1'b1;
                end
            end
            PRIME: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (primed) begin
                    pop        = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (pulse_done) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        fill         = 1'b1;
                        set_underrun = 1'b1;
                    end
                end
                if (!enable) next_state = STOP;
            end
            STOP: begin
                if (pulse_done) begin
                    next_state = IDLE;
                    zero_pw    = 1'b1;
                end else if (enable) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            pending_valid <= 1'b0;
            active        <= '0;
            pulse_width   <= '0;
            pwm_reset     <= 1'b1;
            underrun      <= 1'b0;
        end else begin
            state     <= next_state;
            active    <= next_cfg;
            pwm_reset <= (next_state == IDLE) || (next_state == PRIME);
            if (cfg_write) begin
                pending.compare_max     <= CFG_BITS'(cfg_compare_max);
                pending.dual_slope_en   <= cfg_dual_slope_en;
                pending.double_slope_en <= cfg_double_slope_en;
                pending_valid           <= 1'b1;
            end else if (apply_cfg) begin
                pending_valid <= 1'b0;
            end
            if (pop)          pulse_width <= clamp(head, next_cm);
            else if (zero_pw) pulse_width <= '0;
            else if (fill)    pulse_width <= fill_value;
            if (clr_underrun)      underrun <= 1'b0;
            else if (set_underrun) underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed self-checking bench for pwm_sample_sequencer (default parameters).
module tb_pwm_sample_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_write = 1'b0;
    logic [10:0] cfg_compare_max = '0;
    logic        cfg_dual_slope_en = 1'b0;
    logic        cfg_double_slope_en = 1'b0;
    logic [10:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pulse_done = 1'b0;
    logic        pwm_reset;
    logic [10:0] pulse_width;
    logic [10:0] compare_max;
    logic        dual_slope_en;
    logic        double_slope_en;
    logic        running;
    logic        underrun;
    logic [2:0]  fifo_level;

    int tests = 0;
    int fails = 0;

`ifdef PWM_SEQ_UNDERRUN_HOLD_EN
    localparam logic [10:0] UR_PW = 11'd400;
`else
    localparam logic [10:0] UR_PW = 11'd0;
`endif

    pwm_sample_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .cfg_write           (cfg_write),
        .cfg_compare_max     (cfg_compare_max),
        .cfg_dual_slope_en   (cfg_dual_slope_en),
        .cfg_double_slope_en (cfg_double_slope_en),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .pulse_done          (pulse_done),
        .pwm_reset           (pwm_reset),
        .pulse_width         (pulse_width),
        .compare_max         (compare_max),
        .dual_slope_en       (dual_slope_en),
        .double_slope_en     (double_slope_en),
        .running             (running),
        .underrun            (underrun),
        .fifo_level          (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable     = 1'b0;
        in_valid   = 1'b0;
        pulse_done = 1'b0;
        cfg_write  = 1'b0;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
    endtask

    task automatic cfg(input logic [10:0] cm, input logic dual);
        cfg_write         = 1'b1;
        cfg_compare_max   = cm;
        cfg_dual_slope_en = dual;
        tick();
        cfg_write         = 1'b0;
    endtask

    task automatic push(input logic [10:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse();
        pulse_done = 1'b1;
        tick();
        pulse_done = 1'b0;
    endtask

    task automatic start_run();
        enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests++;
        if ({pwm_reset, running, underrun, in_ready} !== 4'b1001) begin
            $display("FAIL reset_flags got %b want 1001",
                     {pwm_reset, running, underrun, in_ready});
            fails++;
        end
        tests++;
        if (pulse_width !== 11'd0 || compare_max !== 11'd0 || fifo_level !== 3'd0) begin
            $display("FAIL reset_values got pw=%0d cm=%0d lvl=%0d want 0 0 0",
                     pulse_width, compare_max, fifo_level);
            fails++;
        end
        reset = 1'b0;
    endtask

    task automatic test_prime_run();
        do_reset();
        cfg(11'd1000, 1'b0);
        tick();
        tests++;
        if (compare_max !== 11'd1000) begin
            $display("FAIL idle_cfg got %0d want 1000", compare_max);
            fails++;
        end
        push(11'd100);
        push(11'd200);
        tests++;
        if (fifo_level !== 3'd2) begin
            $display("FAIL prime_level got %0d want 2", fifo_level);
            fails++;
        end
        enable = 1'b1;
        tick();
        tests++;
        if (pwm_reset !== 1'b1 || running !== 1'b0) begin
            $display("FAIL prime_state got rst=%b run=%b want 1 0", pwm_reset, running);
            fails++;
        end
        tick();
        tests++;
        if (pwm_reset !== 1'b0 || running !== 1'b1 || pulse_width !== 11'd100 ||
            fifo_level !== 3'd1) begin
            $display("FAIL run_start got rst=%b run=%b pw=%0d lvl=%0d want 0 1 100 1",
                     pwm_reset, running, pulse_width, fifo_level);
            fails++;
        end
        pulse();
        tests++;
        if (pulse_width !== 11'd200 || fifo_level !== 3'd0) begin
            $display("FAIL run_next got pw=%0d lvl=%0d want 200 0", pulse_width, fifo_level);
            fails++;
        end
    endtask

    task automatic test_fifo_wrap();
        logic [10:0] exp_pw;
        do_reset();
        cfg(11'd2047, 1'b0);
        for (int i = 0; i < 4; i++) push(11'(10 + i));
        tests++;
        if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
            $display("FAIL full got lvl=%0d rdy=%b want 4 0", fifo_level, in_ready);
            fails++;
        end
        push(11'd99);
        tests++;
        if (fifo_level !== 3'd4) begin
            $display("FAIL drop_push got lvl=%0d want 4", fifo_level);
            fails++;
        end
        start_run();
        tests++;
        if (pulse_width !== 11'd10 || fifo_level !== 3'd3) begin
            $display("FAIL wrap_first got pw=%0d lvl=%0d want 10 3", pulse_width, fifo_level);
            fails++;
        end
        push(11'd14);
        in_valid   = 1'b1;
        in_data    = 11'd15;
        pulse_done = 1'b1;
        tick();
        tests++;
        if (pulse_width !== 11'd11 || fifo_level !== 3'd3) begin
            $display("FAIL full_pop got pw=%0d lvl=%0d want 11 3", pulse_width, fifo_level);
            fails++;
        end
        for (int k = 0; k < 5; k++) begin
            in_data = 11'(15 + k);
            tick();
            exp_pw = 11'(12 + k);
            tests++;
            if (pulse_width !== exp_pw || fifo_level !== 3'd3) begin
                $display("FAIL wrap_pp%0d got pw=%0d lvl=%0d want %0d 3",
                         k, pulse_width, fifo_level, exp_pw);
                fails++;
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_pw = 11'(17 + k);
            tests++;
            if (pulse_width !== exp_pw || fifo_level !== 3'(2 - k)) begin
                $display("FAIL wrap_drain%0d got pw=%0d lvl=%0d want %0d %0d",
                         k, pulse_width, fifo_level, exp_pw, 2 - k);
                fails++;
            end
        end
        pulse_done = 1'b0;
    endtask

    task automatic test_underrun();
        do_reset();
        cfg(11'd1000, 1'b0);
        push(11'd300);
        push(11'd400);
        start_run();
        pulse();
        tests++;
        if (pulse_width !== 11'd400 || underrun !== 1'b0) begin
            $display("FAIL ur_pre got pw=%0d ur=%b want 400 0", pulse_width, underrun);
            fails++;
        end
        pulse();
        tests++;
        if (pulse_width !== UR_PW || underrun !== 1'b1) begin
            $display("FAIL ur_hit got pw=%0d ur=%b want %0d 1", pulse_width, underrun, UR_PW);
            fails++;
        end
        enable = 1'b0;
        tick();
        pulse();
        tests++;
        if (underrun !== 1'b1 || pwm_reset !== 1'b1 || pulse_width !== 11'd0) begin
            $display("FAIL ur_sticky got ur=%b rst=%b pw=%0d want 1 1 0",
                     underrun, pwm_reset, pulse_width);
            fails++;
        end
        enable = 1'b1;
        tick();
        tests++;
        if (underrun !== 1'b0) begin
            $display("FAIL ur_clear got %b want 0", underrun);
            fails++;
        end
    endtask

    task automatic test_cfg_shadow();
        do_reset();
        cfg(11'd1000, 1'b0);
        push(11'd100);
        push(11'd700);
        start_run();
        cfg(11'd500, 1'b1);
        tick();
        tests++;
        if (compare_max !== 11'd1000 || dual_slope_en !== 1'b0 || pulse_width !== 11'd100) begin
            $display("FAIL cfg_hold got cm=%0d ds=%b pw=%0d want 1000 0 100",
                     compare_max, dual_slope_en, pulse_width);
            fails++;
        end
        pulse();
        tests++;
        if (compare_max !== 11'd500 || dual_slope_en !== 1'b1 || pulse_width !== 11'd500) begin
            $display("FAIL cfg_apply got cm=%0d ds=%b pw=%0d want 500 1 500",
                     compare_max, dual_slope_en, pulse_width);
            fails++;
        end
    endtask

    task automatic test_stop();
        do_reset();
        cfg(11'd1000, 1'b0);
        for (int i = 1; i <= 4; i++) push(11'(i));
        start_run();
        enable = 1'b0;
        tick();
        tests++;
        if (running !== 1'b1 || pwm_reset !== 1'b0 || fifo_level !== 3'd3 ||
            pulse_width !== 11'd1) begin
            $display("FAIL stop_wait got run=%b rst=%b lvl=%0d pw=%0d want 1 0 3 1",
                     running, pwm_reset, fifo_level, pulse_width);
            fails++;
        end
        pulse();
        tests++;
        if (running !== 1'b0 || pwm_reset !== 1'b1 || fifo_level !== 3'd3 ||
            pulse_width !== 11'd0) begin
            $display("FAIL stop_idle got run=%b rst=%b lvl=%0d pw=%0d want 0 1 3 0",
                     running, pwm_reset, fifo_level, pulse_width);
            fails++;
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        cfg(11'd1000, 1'b0);
        for (int i = 7; i <= 10; i++) push(11'(i));
        start_run();
        tests++;
        if (fifo_level !== 3'd3 || pulse_width !== 11'd7) begin
            $display("FAIL mid_pre got lvl=%0d pw=%0d want 3 7", fifo_level, pulse_width);
            fails++;
        end
        reset      = 1'b1;
        pulse_done = 1'b1;
        tick();
        pulse_done = 1'b0;
        tests++;
        if (pwm_reset !== 1'b1 || running !== 1'b0 || pulse_width !== 11'd0 ||
            compare_max !== 11'd0 || fifo_level !== 3'd0 || in_ready !== 1'b1) begin
            $display("FAIL mid_reset got rst=%b run=%b pw=%0d cm=%0d lvl=%0d rdy=%b",
                     pwm_reset, running, pulse_width, compare_max, fifo_level, in_ready);
            fails++;
        end
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prime_run();
        test_fifo_wrap();
        test_underrun();
        test_cfg_shadow();
        test_stop();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
